led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer for the 4-LED chaser board path: synchronises the slide-switch inputs,
//   divides the board clock into step ticks and advances a selectable LED pattern
//   (rotate, bounce, fill, blink) in the direction given by dir. Sits between the
//   switch inputs and the led1..led4 pins.
// PARAMETERS
//   CLK_DIV  50_000_000  clk cycles per pattern step (>=2)
//   N_LEDS   4           pattern width; all behaviour below is stated for 4
// PORTS
//   clk    in   1       system clock, rising edge
//   rst    in   1       asynchronous, active-high reset
//   en     in   1       run/pause switch, asynchronous, synchronised inside
//   clr    in   1       synchronous clear to IDLE, single-cycle pulse or level
//   dir    in   1       0 = toward MSB (led[0]->led[3]), 1 = toward LSB; async, synchronised
//   mode   in   2       00 rotate, 01 bounce, 10 fill, 11 blink; async, synchronised
//   led    out  N_LEDS  pattern; led[0]=led1 .. led[3]=led4
//   step   out  1       1-cycle pulse, high in the cycle led takes a new step value
// BEHAVIOUR
//   - Reset: led=0000, step=0, state=IDLE, prescaler=0, bounce dir=0, sync FFs=0.
//   - en, dir and mode pass through 2-FF synchronisers, giving 2 cycles of latency.
//     Only the synchronised copies en_s, dir_s and mode_s are used.
//   - Priority: rst > clr > en_s. clr forces IDLE on the next edge from any state.
//   - FSM states:
//       IDLE:  led=0000, prescaler=0. If en_s=1 -> LOAD.
//       LOAD:  one cycle. led<=seed(mode_s), cur_mode<=mode_s, bdir<=dir_s,
//              prescaler=0, step=0. -> RUN.
//       RUN:   prescaler counts 0..CLK_DIV-1. tick is asserted when it equals
//              CLK_DIV-1, then it wraps to 0.
//              On tick: led<=next(led), step=1.
//              en_s=0 -> PAUSE; led and prescaler are held (a tick in that
//              same cycle is still applied).
//       PAUSE: everything is held. en_s=1 -> RUN, and the prescaler resumes
//              from its held value.
//   - Seeds: rotate 0001 (dir_s=1: 1000), bounce same as rotate, fill 0000, blink 0000.
//   - next():
//       rotate: dir_s=0 gives a left rotate (1000->0001); dir_s=1 gives a right
//               rotate. dir_s is sampled at each tick.
//       bounce: one-hot moves by bdir. At 1000 with bdir=0, bdir flips and the
//               next value is 0100. At 0001 with bdir=1, bdir flips and the next
//               value is 0010. dir_s is ignored after LOAD.
//       fill:   dir_s=0 gives {led[2:0],1}; dir_s=1 gives {1,led[3:1]}.
//               1111 -> 0000 in either direction.
//       blink:  0000 <-> 1111.
//   - Mode change: mode_s is compared with cur_mode only on a tick. If they
//     differ, led<=seed(mode_s), cur_mode<=mode_s, bdir<=dir_s and step=1; the
//     reseed counts as that tick's step.
//   - Timing: the first step after LOAD arrives exactly CLK_DIV cycles after
//     RUN is entered. Step period is CLK_DIV cycles, excluding PAUSE time.
//   - step is registered and is 0 in IDLE, LOAD and PAUSE.
//   - rst asserted mid-step clears everything immediately (async). After release,
//     IDLE is entered and LOAD requires en_s=1 again.
// STRUCTURE
//   - Package led_seq_pkg holds:
//       mode encodings MODE_ROT, MODE_BNC, MODE_FILL, MODE_BLINK;
//       state encodings S_IDLE, S_LOAD, S_RUN, S_PAUSE;
//       functions seed(mode,dir) and next_pat(mode,led,dir,bdir).
//   - Sub-module tick_gen (CLK_DIV): clk, rst, clear, hold -> tick.
//   - The 2-FF synchronisers are inline.
// TESTING  (CLK_DIV=4, all inputs stable for >=3 cycles before check)
//   1 rst=1 mid-run with led=0100 -> led=0000 and step=0 asynchronously; remains
//     IDLE after release while en=0.
//   2 mode=00, dir=0, en 0->1 -> led=0001 by cycle 3 (2 sync + LOAD), then
//     0010, 0100, 1000, 0001, each 4 cycles apart, with a step pulse on each update.
//   3 mode=01, dir=0 -> 0001,0010,0100,1000,0100,0010,0001,0010; dir toggled
//     mid-sequence has no effect.
//   4 mode=10, dir=1 -> 0000,1000,1100,1110,1111,0000. Then mode->11 mid-run:
//     at the next tick led=0000 with step=1, then 1111 one tick later.
//   5 RUN at prescaler=2, en->0 for 20 cycles -> led held and no step pulses.
//     en->1 -> next step arrives 2 sync + 2 cycles later.
//   6 clr pulse in RUN while en=1 -> next cycle IDLE with led=0000, then LOAD and
//     the seed is reloaded on the following cycle.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings and pattern arithmetic for the LED chaser sequencer.
package led_seq_pkg;

    localparam int unsigned LED_W = 4;

    typedef logic [LED_W-1:0] pat_t;

    typedef enum logic [1:0] {
        MODE_ROT   = 2'b00,
        MODE_BNC   = 2'b01,
        MODE_FILL  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10,
        S_PAUSE = 2'b11
    } state_e;

    // Starting pattern for a mode; one-hot modes start at the end they move away from.
    function automatic pat_t seed(input mode_e mode, input logic dir);
        pat_t s;
        case (mode)
            MODE_ROT, MODE_BNC: s = dir ? 4'b1000 : 4'b0001;
            default:            s = 4'b0000;
        endcase
        return s;
    endfunction

    // Pattern value for the next step. dir steers rotate/fill, bdir steers bounce.
    function automatic pat_t next_pat(input mode_e mode, input pat_t led, input logic dir,
                                      input logic bdir);
        pat_t n;
        n = led;
        case (mode)
            MODE_ROT: n = dir ? {led[0], led[3:1]} : {led[2:0], led[3]};
            MODE_BNC: begin
                if (!bdir) begin
                    n = (led == 4'b1000) ? 4'b0100 : {led[2:0], 1'b0};
                end else begin
                    n = (led == 4'b0001) ? 4'b0010 : {1'b0, led[3:1]};
                end
            end
            MODE_FILL: begin
                if (led == 4'b1111) begin
                    n = 4'b0000;
                end else begin
                    n = dir ? {1'b1, led[3:1]} : {led[2:0], 1'b1};
                end
            end
            default: n = ~led;
        endcase
        return n;
    endfunction

    // Bounce direction flips when the lit LED sits at the end it is heading for.
    function automatic logic next_bdir(input pat_t led, input logic bdir);
        logic at_end;
        at_end = (!bdir && led == 4'b1000) || (bdir && led == 4'b0001);
        return at_end ? ~bdir : bdir;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: pulses tick once every CLK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = !clear && !hold && (cnt_q == LAST);

    // Counter: clear wins, hold freezes, otherwise count and wrap on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED chaser sequencer: synchronises switches, paces steps and advances the pattern.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000,
    parameter int unsigned N_LEDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              dir,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              step
);

    logic       en_m, en_s;
    logic       dir_m, dir_s;
    logic [1:0] mode_m, mode_s;
    mode_e      mode_se;

    state_e state_q, state_d;
    pat_t   led_q, led_d;
    mode_e  cur_mode_q, cur_mode_d;
    logic   bdir_q, bdir_d;
    logic   step_q, step_d;

    logic tick;
    logic active;
    logic tg_clear;

    assign mode_se = mode_e'(mode_s);

    // The prescaler also runs in the PAUSE cycle that sees en_s return, so the
    // resume costs no extra cycle beyond synchronisation.
    assign active   = !clr && ((state_q == S_RUN) || (state_q == S_PAUSE && en_s));
    assign tg_clear = clr || (state_q == S_IDLE) || (state_q == S_LOAD);

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(tg_clear),
        .hold (!active),
        .tick (tick)
    );

    // Two-flop synchronisers for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_m   <= 1'b0;
            en_s   <= 1'b0;
            dir_m  <= 1'b0;
            dir_s  <= 1'b0;
            mode_m <= 2'b00;
            mode_s <= 2'b00;
        end else begin
            en_m   <= en;
            en_s   <= en_m;
            dir_m  <= dir;
            dir_s  <= dir_m;
            mode_m <= mode;
            mode_s <= mode_m;
        end
    end

    // Next-state and pattern update; the seed is written on entry to LOAD.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        cur_mode_d = cur_mode_q;
        bdir_d     = bdir_q;
        step_d     = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
            led_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    led_d = '0;
                    if (en_s) begin
                        state_d    = S_LOAD;
                        led_d      = seed(mode_se, dir_s);
                        cur_mode_d = mode_se;
                        bdir_d     = dir_s;
                    end
                end
                S_LOAD:  state_d = S_RUN;
                S_RUN:   if (!en_s) state_d = S_PAUSE;
                S_PAUSE: if (en_s) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
            if (tick) begin
                step_d = 1'b1;
                if (mode_se != cur_mode_q) begin
                    led_d      = seed(mode_se, dir_s);
                    cur_mode_d = mode_se;
                    bdir_d     = dir_s;
                end else begin
                    led_d = next_pat(cur_mode_q, led_q, dir_s, bdir_q);
                    if (cur_mode_q == MODE_BNC) begin
                        bdir_d = next_bdir(led_q, bdir_q);
                    end
                end
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            led_q      <= '0;
            cur_mode_q <= MODE_ROT;
            bdir_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            cur_mode_q <= cur_mode_d;
            bdir_q     <= bdir_d;
            step_q     <= step_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with CLK_DIV=4.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] led;
    logic       step;

    int n_vec = 0;
    int n_err = 0;

    // Expected step: pattern and cycles since the previous observation point.
    typedef struct {
        logic [3:0] led;
        int         gap;
    } exp_t;

    exp_t sb[$];

    led_seq_ctrl #(
        .CLK_DIV(4),
        .N_LEDS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr),
        .dir (dir),
        .mode(mode),
        .led (led),
        .step(step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Advance until a step pulse is seen or the budget runs out.
    task automatic wait_step(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick_clk();
            cycles++;
            if (step === 1'b1) seen = 1'b1;
        end
    endtask

    // Park in IDLE, set mode/dir, then raise en; returns three edges after en rises.
    task automatic start_run(input logic [1:0] m, input logic d);
        en   = 1'b0;
        clr  = 1'b1;
        mode = m;
        dir  = d;
        repeat (3) tick_clk();
        clr = 1'b0;
        repeat (2) tick_clk();
        en = 1'b1;
        repeat (3) tick_clk();
    endtask

    task automatic test_reset();
        int bad;
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        dir  = 1'b0;
        mode = 2'b00;
        repeat (2) tick_clk();
        n_vec++;
        if (led !== 4'b0000 || step !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: led=%b step=%b, want 0000/0", led, step);
        end
        #2 rst = 1'b0;
        bad = 0;
        repeat (6) begin
            tick_clk();
            if (led !== 4'b0000 || step !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_idle: %0d cycles left idle, want 0", bad);
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        int   cyc;
        bit   seen;
        start_run(2'b00, 1'b0);
        n_vec++;
        if (led !== 4'b0001 || step !== 1'b0) begin
            n_err++;
            $display("FAIL rot_seed: led=%b step=%b, want 0001/0", led, step);
        end
        sb.push_back('{4'b0010, 5});
        sb.push_back('{4'b0100, 4});
        sb.push_back('{4'b1000, 4});
        sb.push_back('{4'b0001, 4});
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_step(12, cyc, seen);
            n_vec++;
            if (!seen || led !== e.led || cyc != e.gap) begin
                n_err++;
                $display("FAIL rot_step: seen=%0d led=%b after %0d, want %b after %0d",
                         seen, led, cyc, e.led, e.gap);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int   cyc;
        int   k;
        bit   seen;
        start_run(2'b01, 1'b0);
        n_vec++;
        if (led !== 4'b0001) begin
            n_err++;
            $display("FAIL bnc_seed: led=%b, want 0001", led);
        end
        sb.push_back('{4'b0010, 5});
        sb.push_back('{4'b0100, 4});
        sb.push_back('{4'b1000, 4});
        sb.push_back('{4'b0100, 4});
        sb.push_back('{4'b0010, 4});
        sb.push_back('{4'b0001, 4});
        sb.push_back('{4'b0010, 4});
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_step(12, cyc, seen);
            n_vec++;
            if (!seen || led !== e.led || cyc != e.gap) begin
                n_err++;
                $display("FAIL bnc_step%0d: seen=%0d led=%b after %0d, want %b after %0d",
                         k, seen, led, cyc, e.led, e.gap);
            end
            k++;
            if (k == 3) dir = ~dir;
        end
    endtask

    task automatic test_fill_blink();
        exp_t e;
        int   cyc;
        bit   seen;
        start_run(2'b10, 1'b1);
        n_vec++;
        if (led !== 4'b0000) begin
            n_err++;
            $display("FAIL fill_seed: led=%b, want 0000", led);
        end
        sb.push_back('{4'b1000, 5});
        sb.push_back('{4'b1100, 4});
        sb.push_back('{4'b1110, 4});
        sb.push_back('{4'b1111, 4});
        sb.push_back('{4'b0000, 4});
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_step(12, cyc, seen);
            n_vec++;
            if (!seen || led !== e.led || cyc != e.gap) begin
                n_err++;
                $display("FAIL fill_step: seen=%0d led=%b after %0d, want %b after %0d",
                         seen, led, cyc, e.led, e.gap);
            end
        end
        mode = 2'b11;
        sb.push_back('{4'b0000, 4});
        sb.push_back('{4'b1111, 4});
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_step(12, cyc, seen);
            n_vec++;
            if (!seen || led !== e.led || cyc != e.gap) begin
                n_err++;
                $display("FAIL blink_step: seen=%0d led=%b after %0d, want %b after %0d",
                         seen, led, cyc, e.led, e.gap);
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int   cyc;
        int   bad;
        bit   seen;
        start_run(2'b00, 1'b0);
        wait_step(12, cyc, seen);
        n_vec++;
        if (!seen || led !== 4'b0010 || cyc != 5) begin
            n_err++;
            $display("FAIL pause_pre: seen=%0d led=%b after %0d, want 0010 after 5",
                     seen, led, cyc);
        end
        // Drop en so that the prescaler is frozen at 2.
        repeat (3) tick_clk();
        en = 1'b0;
        tick_clk();
        n_vec++;
        if (step !== 1'b1 || led !== 4'b0100) begin
            n_err++;
            $display("FAIL pause_last: led=%b step=%b, want 0100/1", led, step);
        end
        bad = 0;
        repeat (20) begin
            tick_clk();
            if (step !== 1'b0 || led !== 4'b0100) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL pause_hold: %0d cycles moved, want 0", bad);
        end
        en = 1'b1;
        sb.push_back('{4'b1000, 4});
        sb.push_back('{4'b0001, 4});
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_step(12, cyc, seen);
            n_vec++;
            if (!seen || led !== e.led || cyc != e.gap) begin
                n_err++;
                $display("FAIL pause_resume: seen=%0d led=%b after %0d, want %b after %0d",
                         seen, led, cyc, e.led, e.gap);
            end
        end
    endtask

    task automatic test_clear();
        int cyc;
        bit seen;
        wait_step(12, cyc, seen);
        n_vec++;
        if (!seen || led !== 4'b0010 || cyc != 4) begin
            n_err++;
            $display("FAIL clr_pre: seen=%0d led=%b after %0d, want 0010 after 4",
                     seen, led, cyc);
        end
        tick_clk();
        clr = 1'b1;
        tick_clk();
        clr = 1'b0;
        n_vec++;
        if (led !== 4'b0000 || step !== 1'b0) begin
            n_err++;
            $display("FAIL clr_idle: led=%b step=%b, want 0000/0", led, step);
        end
        tick_clk();
        n_vec++;
        if (led !== 4'b0001 || step !== 1'b0) begin
            n_err++;
            $display("FAIL clr_reload: led=%b step=%b, want 0001/0", led, step);
        end
        wait_step(12, cyc, seen);
        n_vec++;
        if (!seen || led !== 4'b0010 || cyc != 5) begin
            n_err++;
            $display("FAIL clr_first: seen=%0d led=%b after %0d, want 0010 after 5",
                     seen, led, cyc);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        int bad;
        bit seen;
        wait_step(12, cyc, seen);
        n_vec++;
        if (!seen || led !== 4'b0100 || cyc != 4) begin
            n_err++;
            $display("FAIL arst_pre: seen=%0d led=%b after %0d, want 0100 after 4",
                     seen, led, cyc);
        end
        // Mid-cycle assertion while step is still high.
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (led !== 4'b0000 || step !== 1'b0) begin
            n_err++;
            $display("FAIL arst_now: led=%b step=%b, want 0000/0", led, step);
        end
        en = 1'b0;
        repeat (2) tick_clk();
        #2 rst = 1'b0;
        bad = 0;
        repeat (12) begin
            tick_clk();
            if (led !== 4'b0000 || step !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL arst_idle: %0d cycles left idle, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_bounce();
        test_fill_blink();
        test_pause();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
